// File: rtl/fifo_pkt_writer_pkg.sv
// Shared definitions for the packet writer: FSM encoding, header tag,
// default downstream depth and the header-byte builder.
package fifo_pkt_writer_pkg;

    // Writer FSM states.
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_SPACE = 2'd1,
        PAYLOAD    = 2'd2
    } state_e;

    // Upper nibble of every header byte.
    localparam logic [3:0] HDR_TAG = 4'hA;

    // Default downstream FIFO capacity in bytes (initial credit count).
    localparam int DEPTH_DEFAULT = 8;

    // Width of the credit counter; holds 0..DEPTH.
    localparam int CRED_W = 4;

    // Header byte layout: tag, a reserved zero bit, then the payload length.
    function automatic logic [7:0] hdr_byte(input logic [2:0] len);
        return {HDR_TAG, 1'b0, len};
    endfunction

endpackage

// File: rtl/fifo_pkt_writer_if.sv
// Bus bundle for the packet writer.
// Handshakes: a transfer happens on a rising write_clk edge where valid and
// ready are both high; ready is never derived from valid, and a request not
// taken is simply not transferred.
interface fifo_pkt_writer_if;
    import fifo_pkt_writer_pkg::*;

    // Packet request channel.
    logic                pkt_valid;
    logic [2:0]          pkt_len;
    logic                pkt_ready;
    // Payload byte channel.
    logic [7:0]          src_data;
    logic                src_valid;
    logic                src_ready;
    // Downstream FIFO write port and credit return.
    logic                fifo_wr_en;
    logic [7:0]          fifo_data;
    logic                fifo_rd_ack;
    // Status.
    logic [CRED_W-1:0]   credits;
    logic                pkt_done;
    logic                err_underflow;

    // Environment side: drives requests, payload and read acks.
    modport master (
        output pkt_valid, pkt_len, src_data, src_valid, fifo_rd_ack,
        input  pkt_ready, src_ready, fifo_wr_en, fifo_data, credits,
               pkt_done, err_underflow
    );

    // Writer side.
    modport slave (
        input  pkt_valid, pkt_len, src_data, src_valid, fifo_rd_ack,
        output pkt_ready, src_ready, fifo_wr_en, fifo_data, credits,
               pkt_done, err_underflow
    );

endinterface

// File: rtl/fifo_pkt_writer_credit_cnt.sv
// Downstream free-slot counter. dec marks a write issued this cycle, inc a
// byte popped downstream. A pop while already at DEPTH with no write is a
// protocol error: it is not counted and raises a sticky flag.
module fifo_credit_cnt
    import fifo_pkt_writer_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic              write_clk,
    input  logic              reset,
    input  logic              dec,
    input  logic              inc,
    output logic [CRED_W-1:0] credits,
    output logic              err_underflow
);

    localparam logic [CRED_W-1:0] DEPTH_C = CRED_W'(DEPTH);

    logic [CRED_W-1:0] credits_q, credits_d;
    logic              err_q, err_d;

    // Next credit count and error flag.
    always_comb begin
        credits_d = credits_q;
        err_d     = err_q;
        if (inc && !dec) begin
            if (credits_q == DEPTH_C) begin
                err_d = 1'b1;
            end else begin
                credits_d = credits_q + 1'b1;
            end
        end else if (dec && !inc) begin
            credits_d = credits_q - 1'b1;
        end
    end

    // Counter and sticky error registers.
    always_ff @(posedge write_clk) begin
        if (reset) begin
            credits_q <= DEPTH_C;
            err_q     <= 1'b0;
        end else begin
            credits_q <= credits_d;
            err_q     <= err_d;
        end
    end

    assign credits       = credits_q;
    assign err_underflow = err_q;

endmodule

// File: rtl/fifo_pkt_writer.sv
// Packet writer: accepts a length request, waits until the downstream FIFO
// has room for header plus the whole payload, then emits the header byte
// followed by the payload bytes. All writes leave through a register stage.
module fifo_pkt_writer
    import fifo_pkt_writer_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                 write_clk,
    input  logic                 reset,
    fifo_pkt_writer_if.slave     bus,
    output state_e               dbg_state
);

    state_e      state_q, state_d;
    logic [2:0]  len_q, len_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        wr_en_q, wr_en_d;
    logic [7:0]  data_q, data_d;
    logic        done_q, done_d;

    logic        issue;
    logic        issue_last;
    logic [7:0]  issue_data;
    logic        pkt_ready;
    logic        src_ready;
    logic [2:0]  cnt_inc;
    logic [CRED_W-1:0] need;
    logic [CRED_W-1:0] credits;

    assign cnt_inc = cnt_q + 3'd1;
    // Header plus payload; reserving all of it up front means payload
    // writes can never run past the downstream capacity.
    assign need    = {1'b0, len_q} + {{(CRED_W-1){1'b0}}, 1'b1};

    // FSM next state, issue decision and handshake readies.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        issue      = 1'b0;
        issue_last = 1'b0;
        issue_data = data_q;
        pkt_ready  = 1'b0;
        src_ready  = 1'b0;
        unique case (state_q)
            IDLE: begin
                pkt_ready = 1'b1;
                if (bus.pkt_valid) begin
                    len_d   = bus.pkt_len;
                    cnt_d   = 3'd0;
                    state_d = WAIT_SPACE;
                end
            end
            WAIT_SPACE: begin
                if (credits >= need) begin
                    issue      = 1'b1;
                    issue_data = hdr_byte(len_q);
                    if (len_q == 3'd0) begin
                        issue_last = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        state_d    = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                src_ready = 1'b1;
                if (bus.src_valid) begin
                    issue      = 1'b1;
                    issue_data = bus.src_data;
                    cnt_d      = cnt_inc;
                    if (cnt_inc == len_q) begin
                        issue_last = 1'b1;
                        cnt_d      = 3'd0;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output stage: a write shows up one cycle after it is issued; data
    // holds its last value between writes.
    always_comb begin
        wr_en_d = issue;
        data_d  = issue ? issue_data : data_q;
        done_d  = issue_last;
    end

    // State, packet context and output registers.
    always_ff @(posedge write_clk) begin
        if (reset) begin
            state_q <= IDLE;
            len_q   <= 3'd0;
            cnt_q   <= 3'd0;
            wr_en_q <= 1'b0;
            data_q  <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            wr_en_q <= wr_en_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    fifo_credit_cnt #(
        .DEPTH (DEPTH)
    ) u_credit_cnt (
        .write_clk     (write_clk),
        .reset         (reset),
        .dec           (issue),
        .inc           (bus.fifo_rd_ack),
        .credits       (credits),
        .err_underflow (bus.err_underflow)
    );

    assign bus.pkt_ready  = pkt_ready;
    assign bus.src_ready  = src_ready;
    assign bus.fifo_wr_en = wr_en_q;
    assign bus.fifo_data  = data_q;
    assign bus.pkt_done   = done_q;
    assign bus.credits    = credits;
    assign dbg_state      = state_q;

endmodule

// File: doc/fifo_pkt_writer.md
FIFO_PKT_WRITER -- requirements
Module: fifo_pkt_writer

Interface
REQ-001 SHALL provide parameter: DEPTH, 8, downstream FIFO capacity in bytes (initial credit count).
REQ-002 SHALL provide port: write_clk  in  1  clock; all logic on its rising edge.
REQ-003 SHALL provide port: reset  in  1  reset, synchronous, active-high.
REQ-004 SHALL provide port: pkt_valid  in  1  packet request.
REQ-005 SHALL provide port: pkt_len  in  3  payload byte count, 0..7.
REQ-006 SHALL provide port: pkt_ready  out  1  request accept strobe.
REQ-007 SHALL provide port: src_data  in  8  payload byte.
REQ-008 SHALL provide port: src_valid  in  1  payload byte valid.
REQ-009 SHALL provide port: src_ready  out  1  payload byte accept.
REQ-010 SHALL provide port: fifo_wr_en  out  1  registered write strobe to downstream FIFO.
REQ-011 SHALL provide port: fifo_data  out  8  registered write data.
REQ-012 SHALL provide port: fifo_rd_ack  in  1  one pulse per byte popped downstream, already in write_clk domain.
REQ-013 SHALL provide port: credits  out  4  free downstream slots.
REQ-014 SHALL provide port: pkt_done  out  1  one-cycle pulse coincident with a packet's final fifo_wr_en.
REQ-015 SHALL provide port: err_underflow  out  1  sticky credit-underflow error.

Function
REQ-016 SHALL use the states IDLE, WAIT_SPACE, and PAYLOAD.
REQ-017 SHALL drive pkt_ready=1 only in IDLE; on pkt_valid&pkt_ready, SHALL latch pkt_len and go to WAIT_SPACE.
REQ-018 In WAIT_SPACE, when credits >= latched_len+1, SHALL issue the header write {4'hA,1'b0,len} and go to PAYLOAD (len>0) or IDLE (len=0).
REQ-019 In PAYLOAD, SHALL drive src_ready=1; each src_valid&src_ready SHALL issue a write of src_data; after len issued bytes, SHALL return to IDLE.
REQ-020 Each issued write SHALL appear on fifo_wr_en/fifo_data exactly one cycle after the issue cycle; fifo_wr_en SHALL be 0 otherwise, and fifo_data SHALL hold its last value.
REQ-021 Because space is reserved in WAIT_SPACE, payload writes SHALL never exceed credits; src_valid gaps SHALL insert idle cycles only.
REQ-022 credits SHALL decrement by 1 per issued write and increment by 1 per fifo_rd_ack; a simultaneous write and ack SHALL leave credits unchanged.
REQ-023 A fifo_rd_ack arriving with credits==DEPTH and no simultaneous write SHALL be ignored for counting and SHALL set err_underflow=1 until reset.
REQ-024 pkt_done SHALL pulse in the same cycle as the fifo_wr_en of the header (len=0) or of the last payload byte.
REQ-025 pkt_valid held while not in IDLE SHALL be ignored, not queued.

Reset
REQ-026 Reset SHALL be synchronous, active-high, sampled on write_clk, and SHALL take priority over all other events, including mid-packet.
REQ-027 Reset SHALL force state=IDLE, credits=DEPTH, fifo_wr_en=0, fifo_data=8'h00, pkt_done=0, err_underflow=0, and the latched length and byte counter to 0.
REQ-028 Reset mid-packet SHALL abandon the packet; bytes already written SHALL not be recalled.

Structure
REQ-029 A shared package SHALL hold the state encoding, the HDR_TAG=4'hA constant, and the DEPTH default.
REQ-030 Credit counting SHALL reside in one sub-module, fifo_credit_cnt (inputs: dec, inc; outputs: credits, err_underflow); the FSM and datapath SHALL reside in the top module.

Verification
REQ-031 Reset then pkt_len=3 with bytes 11,22,33 back-to-back -> fifo_data A3,11,22,33 on 4 consecutive cycles; pkt_done on the cycle of 33; credits=4.
REQ-032 pkt_len=0 -> single write A0 with pkt_done; return to IDLE; credits=7.
REQ-033 Fill to credits=2, request len=3 -> held in WAIT_SPACE with no writes; two fifo_rd_ack pulses -> header issued the cycle after credits reaches 4.
REQ-034 Issued write and fifo_rd_ack in the same cycle -> credits unchanged; fifo_rd_ack at credits=8 -> err_underflow=1, credits stays 8.
REQ-035 Reset asserted after the 2nd payload byte of len=5 -> next cycle IDLE, credits=8, pkt_ready=1, no further writes.
REQ-036 src_valid toggling 1,0,1,0 during len=2 -> writes only on valid cycles, with no extra or missing bytes.
